alu_cmd_issuer: RTL and testbench



---
 rtl/alu_cmd_issuer.sv | 186 ++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands in a small FIFO and issues them one at a time to a registered ALU.
// Each result is returned in command order with its tag and a divide-by-zero flag.
module alu_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_in1,
  input  logic [3:0]             cmd_in2,
  input  logic [2:0]             cmd_opcode,
  output logic [3:0]             alu_in1,
  output logic [3:0]             alu_in2,
  output logic [2:0]             alu_opcode,
  input  logic [7:0]             alu_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_result,
  output logic [2:0]             rsp_opcode,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int WCW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [3:0]       in1;
    logic [3:0]       in2;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head, entry_in;
  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [TAG_W-1:0] tag_q, tag_d, cur_tag_q, cur_tag_d;
  logic             cmd_ready_q, cmd_ready_d, cur_err_q, cur_err_d;
  logic [3:0]       alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [7:0]       rsp_result_q, rsp_result_d;
  logic [2:0]       rsp_opcode_q, rsp_opcode_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             push, pop;

  assign head     = mem_q[rd_ptr_q];
  assign entry_in = '{in1: cmd_in1, in2: cmd_in2, op: cmd_opcode, tag: tag_q};
  assign push     = cmd_valid & cmd_ready_q;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    tag_d        = tag_q;
    cur_tag_d    = cur_tag_q;
    cur_err_d    = cur_err_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      tag_d    = tag_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    // Ready is a pure function of occupancy; a pop in the same cycle never frees a slot early.
    cmd_ready_d = (count_d != CW'(DEPTH));

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          rd_ptr_d  = rd_ptr_q + 1'b1;
          alu_in1_d = head.in1;
          alu_in2_d = head.in2;
          alu_op_d  = head.op;
          cur_tag_d = head.tag;
          cur_err_d = (head.op == 3'b011) && (head.in2 == 4'h0);
          wait_d    = WCW'(LATENCY);
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          rsp_valid_d  = 1'b1;
          rsp_result_d = cur_err_q ? 8'h00 : alu_out;
          rsp_opcode_d = alu_op_q;
          rsp_tag_d    = cur_tag_q;
          rsp_err_d    = cur_err_q;
          state_d      = S_RESP;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tag_q        <= '0;
      cur_tag_q    <= '0;
      cur_err_q    <= 1'b0;
      cmd_ready_q  <= 1'b0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_opcode_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tag_q        <= tag_d;
      cur_tag_q    <= cur_tag_d;
      cur_err_q    <= cur_err_d;
      cmd_ready_q  <= cmd_ready_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_in;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign alu_opcode = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_opcode = rsp_opcode_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a registered ALU stub, directed scenarios and a random run,
// all checked against an arithmetic reference model and an in-order expectation queue.
module tb_alu_cmd_issuer;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 1;
  localparam int TAG_W   = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_in1 = '0, cmd_in2 = '0;
  logic [2:0]       cmd_opcode = '0;
  logic [3:0]       alu_in1, alu_in2;
  logic [2:0]       alu_opcode;
  logic [7:0]       alu_out = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [7:0]       rsp_result;
  logic [2:0]       rsp_opcode;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;
  logic [$clog2(DEPTH):0] fifo_count;

  typedef struct {
    logic [7:0]       res;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               cyc;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  logic [TAG_W-1:0] tb_tag = '0;
  int checks = 0, passes = 0, hold_viol = 0, acc_edge = 0, cyc = 0;

  alu_cmd_issuer #(.DEPTH(DEPTH), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_in1(cmd_in1), .cmd_in2(cmd_in2), .cmd_opcode(cmd_opcode),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_opcode(rsp_opcode), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Registered ALU stand-in; divide by zero returns junk that must never surface.
  always @(posedge clock) begin
    case (alu_opcode)
      3'd0: alu_out <= {4'h0, alu_in1} + {4'h0, alu_in2};
      3'd1: alu_out <= {4'h0, alu_in1} - {4'h0, alu_in2};
      3'd2: alu_out <= {4'h0, alu_in1} * {4'h0, alu_in2};
      3'd3: alu_out <= (alu_in2 == 4'h0) ? 8'hAA : ({4'h0, alu_in1} / {4'h0, alu_in2});
      3'd4: alu_out <= {4'h0, alu_in1 | alu_in2};
      3'd5: alu_out <= {4'h0, alu_in1 & alu_in2};
      3'd6: alu_out <= ~{4'h0, alu_in1 & alu_in2};
      default: alu_out <= ~{4'h0, alu_in1 | alu_in2};
    endcase
  end

  function automatic rsp_t model(input logic [3:0] a, input logic [3:0] b,
                                 input logic [2:0] op, input logic [TAG_W-1:0] tag);
    int x = int'(a);
    int y = int'(b);
    int r = 0;
    rsp_t m;
    m.err = 1'b0;
    case (op)
      3'd0: r = x + y;
      3'd1: r = (x - y + 256) % 256;
      3'd2: r = x * y;
      3'd3: if (y == 0) m.err = 1'b1; else r = x / y;
      3'd4: r = x | y;
      3'd5: r = x & y;
      3'd6: r = 255 - (x & y);
      default: r = 255 - (x | y);
    endcase
    m.res = 8'(r);
    m.op  = op;
    m.tag = tag;
    m.cyc = 0;
    return m;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int guard = 0;
    bit done = 1'b0;
    cmd_in1 = a; cmd_in2 = b; cmd_opcode = op; cmd_valid = 1'b1;
    while (!done && guard < 200) begin
      if (cmd_ready) begin
        done = 1'b1;
        acc_edge = cyc + 1;
        exp_q.push_back(model(a, b, op, tb_tag));
        tb_tag = tb_tag + 1'b1;
      end
      @(negedge clock);
      guard++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!done) $display("FAIL send_accept got=never_accepted want=accepted op=%0d", op);
    else passes++;
  endtask

  task automatic recv(input int n, input bit rand_ready, output int got);
    int guard = 0;
    bit stalled = 1'b0;
    logic [16:0] prev = '0;
    got = 0;
    while (got < n && guard < 2000) begin
      if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
      if (stalled && ({rsp_valid, rsp_result, rsp_opcode, rsp_tag, rsp_err} !== prev)) hold_viol++;
      stalled = rsp_valid && !rsp_ready;
      prev = {rsp_valid, rsp_result, rsp_opcode, rsp_tag, rsp_err};
      if (rsp_valid && rsp_ready) begin
        obs_q.push_back('{rsp_result, rsp_opcode, rsp_tag, rsp_err, cyc});
        $display("rsp tag=%0d op=%0d result=%02h err=%0b edge=%0d",
                 rsp_tag, rsp_opcode, rsp_result, rsp_err, cyc);
        got++;
      end
      @(negedge clock);
      guard++;
    end
    rsp_ready = 1'b1;
    checks++;
    if (got != n) $display("FAIL recv_count got=%0d want=%0d", got, n);
    else passes++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete(); obs_q.delete(); tb_tag = '0; hold_viol = 0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got=%0b want=0", cmd_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); else passes++;
    checks++; if (fifo_count !== '0) $display("FAIL reset_fifo_count got=%0d want=0", fifo_count); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b want=0", busy); else passes++;
    checks++; if ({alu_in1, alu_in2, alu_opcode} !== 11'h0) $display("FAIL reset_alu got=%h want=0", {alu_in1, alu_in2, alu_opcode}); else passes++;
    checks++; if ({rsp_result, rsp_opcode, rsp_tag, rsp_err} !== 16'h0) $display("FAIL reset_rsp got=%h want=0", {rsp_result, rsp_opcode, rsp_tag, rsp_err}); else passes++;
    reset = 1'b1;
    @(negedge clock);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got=%0b want=1", cmd_ready); else passes++;
  endtask

  task automatic test_basic_add();
    int got;
    do_reset();
    send(4'd7, 4'd5, 3'd0);
    @(negedge clock);
    checks++; if ({alu_in1, alu_in2, alu_opcode} !== {4'd7, 4'd5, 3'd0}) $display("FAIL add_alu_drive got=%h want=%h", {alu_in1, alu_in2, alu_opcode}, {4'd7, 4'd5, 3'd0}); else passes++;
    checks++; if (busy !== 1'b1 || fifo_count !== '0) $display("FAIL add_busy got=%0b/%0d want=1/0", busy, fifo_count); else passes++;
    recv(1, 1'b0, got);
    if (obs_q.size() >= 1) begin
      checks++; if ({obs_q[0].res, obs_q[0].op, obs_q[0].tag, obs_q[0].err} !== {8'h0C, 3'd0, 4'd0, 1'b0}) $display("FAIL add_rsp got=%h/%0d/%0d want=0c/0/0", obs_q[0].res, obs_q[0].tag, obs_q[0].err); else passes++;
      checks++; if (obs_q[0].cyc != acc_edge + LATENCY + 2) $display("FAIL add_latency got_edge=%0d want_edge=%0d", obs_q[0].cyc, acc_edge + LATENCY + 2); else passes++;
    end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL add_drain got=%0b/%0b want=0/0", rsp_valid, busy); else passes++;
  endtask

  task automatic test_back_to_back();
    int got;
    do_reset();
    send(4'd3, 4'd5, 3'd1);
    send(4'd15, 4'd15, 3'd2);
    recv(2, 1'b0, got);
    if (obs_q.size() >= 2) begin
      checks++; if ({obs_q[0].res, obs_q[0].tag} !== {8'hFE, 4'd0}) $display("FAIL b2b_first got=%h/%0d want=fe/0", obs_q[0].res, obs_q[0].tag); else passes++;
      checks++; if ({obs_q[1].res, obs_q[1].tag} !== {8'hE1, 4'd1}) $display("FAIL b2b_second got=%h/%0d want=e1/1", obs_q[1].res, obs_q[1].tag); else passes++;
      checks++; if (obs_q[1].cyc - obs_q[0].cyc != 4) $display("FAIL b2b_spacing got=%0d want=4", obs_q[1].cyc - obs_q[0].cyc); else passes++;
    end
  endtask

  task automatic test_div_err();
    int got;
    do_reset();
    send(4'd9, 4'd0, 3'd3);
    recv(1, 1'b0, got);
    send(4'd9, 4'd2, 3'd3);
    recv(1, 1'b0, got);
    if (obs_q.size() >= 2) begin
      checks++; if ({obs_q[0].res, obs_q[0].err} !== {8'h00, 1'b1}) $display("FAIL div0 got=%h/%0b want=00/1", obs_q[0].res, obs_q[0].err); else passes++;
      checks++; if ({obs_q[1].res, obs_q[1].err, obs_q[1].tag} !== {8'h04, 1'b0, 4'd1}) $display("FAIL div_ok got=%h/%0b/%0d want=04/0/1", obs_q[1].res, obs_q[1].err, obs_q[1].tag); else passes++;
    end
  endtask

  task automatic test_logic_ops();
    logic [3:0] a, b;
    logic [2:0] op;
    logic [7:0] want;
    int bad, guard;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 4'hA : 4'hF;
      b = (i == 0) ? 4'h5 : 4'hF;
      op = (i == 0) ? 3'd4 : 3'd6;
      want = (i == 0) ? 8'h0F : 8'hF0;
      send(a, b, op);
      @(negedge clock);
      bad = 0; guard = 0;
      while (!rsp_valid && guard < 20) begin
        if ({alu_in1, alu_in2, alu_opcode} !== {a, b, op}) bad++;
        @(negedge clock);
        guard++;
      end
      if ({alu_in1, alu_in2, alu_opcode} !== {a, b, op}) bad++;
      checks++; if (bad != 0) $display("FAIL logic_alu_stable got=%0d_changes want=0 op=%0d", bad, op); else passes++;
      checks++; if (rsp_valid !== 1'b1 || rsp_result !== want) $display("FAIL logic_result got=%0b/%h want=1/%h", rsp_valid, rsp_result, want); else passes++;
      @(negedge clock);
    end
    repeat (3) @(negedge clock);
    checks++; if ({alu_in1, alu_in2, alu_opcode} !== {4'hF, 4'hF, 3'd6}) $display("FAIL idle_alu_hold got=%h want=%h", {alu_in1, alu_in2, alu_opcode}, {4'hF, 4'hF, 3'd6}); else passes++;
  endtask

  task automatic test_backpressure();
    int got, accepted = 0, changes = 0;
    logic [16:0] snap;
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(4'($urandom), 4'($urandom), 3'($urandom));
    checks++; if (cmd_ready !== 1'b0 || fifo_count !== 3'd4) $display("FAIL bp_full got=%0b/%0d want=0/4", cmd_ready, fifo_count); else passes++;
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'd0) $display("FAIL bp_held_rsp got=%0b/%0d want=1/0", rsp_valid, rsp_tag); else passes++;
    snap = {rsp_valid, rsp_result, rsp_opcode, rsp_tag, rsp_err};
    cmd_in1 = 4'd1; cmd_in2 = 4'd1; cmd_opcode = 3'd0; cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (cmd_ready) accepted++;
      if ({rsp_valid, rsp_result, rsp_opcode, rsp_tag, rsp_err} !== snap) changes++;
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    checks++; if (accepted != 0) $display("FAIL bp_sixth_blocked got=%0d_ready_cycles want=0", accepted); else passes++;
    checks++; if (changes != 0) $display("FAIL bp_rsp_stable got=%0d_changes want=0", changes); else passes++;
    rsp_ready = 1'b1;
    fork
      send(4'($urandom), 4'($urandom), 3'($urandom));
      recv(6, 1'b0, got);
    join
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if ({obs_q[i].res, obs_q[i].op, obs_q[i].tag, obs_q[i].err} !== {exp_q[i].res, exp_q[i].op, 4'(i), exp_q[i].err})
        $display("FAIL bp_order[%0d] got=%h/%0d/%0d want=%h/%0d/%0d", i, obs_q[i].res, obs_q[i].tag, obs_q[i].err, exp_q[i].res, i, exp_q[i].err);
      else passes++;
    end
  endtask

  task automatic test_reset_midflight();
    int got;
    do_reset();
    send(4'd1, 4'd1, 3'd0);
    send(4'd2, 4'd2, 3'd0);
    send(4'd3, 4'd3, 3'd0);
    checks++; if (fifo_count !== 3'd2 || rsp_valid !== 1'b0) $display("FAIL mid_pre got=%0d/%0b want=2/0", fifo_count, rsp_valid); else passes++;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    checks++; if (rsp_valid !== 1'b0 || fifo_count !== '0 || busy !== 1'b0) $display("FAIL mid_reset got=%0b/%0d/%0b want=0/0/0", rsp_valid, fifo_count, busy); else passes++;
    checks++; if ({alu_in1, alu_in2, alu_opcode} !== 11'h0) $display("FAIL mid_alu got=%h want=0", {alu_in1, alu_in2, alu_opcode}); else passes++;
    exp_q.delete(); obs_q.delete(); tb_tag = '0;
    @(negedge clock);
    send(4'd2, 4'd3, 3'd0);
    recv(1, 1'b0, got);
    if (obs_q.size() >= 1) begin
      checks++; if ({obs_q[0].res, obs_q[0].tag} !== {8'h05, 4'd0}) $display("FAIL mid_restart got=%h/%0d want=05/0", obs_q[0].res, obs_q[0].tag); else passes++;
    end
    checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_no_stale got=%0b want=0", rsp_valid); else passes++;
  endtask

  task automatic test_tag_wrap();
    int got;
    do_reset();
    fork
      for (int i = 0; i < 17; i++) send(4'($urandom), 4'($urandom), 3'($urandom));
      recv(17, 1'b0, got);
    join
    if (obs_q.size() >= 17) begin
      checks++; if (obs_q[16].tag !== 4'd0) $display("FAIL wrap_tag got=%0d want=0", obs_q[16].tag); else passes++;
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if ({obs_q[i].res, obs_q[i].op, obs_q[i].tag, obs_q[i].err} !== {exp_q[i].res, exp_q[i].op, exp_q[i].tag, exp_q[i].err})
        $display("FAIL wrap_rsp[%0d] got=%h/%0d/%0d want=%h/%0d/%0d", i, obs_q[i].res, obs_q[i].tag, obs_q[i].err, exp_q[i].res, exp_q[i].tag, exp_q[i].err);
      else passes++;
    end
  endtask

  task automatic test_random();
    int got;
    do_reset();
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clock);
        send(4'($urandom), 4'($urandom), 3'($urandom));
      end
      recv(40, 1'b1, got);
    join
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if ({obs_q[i].res, obs_q[i].op, obs_q[i].tag, obs_q[i].err} !== {exp_q[i].res, exp_q[i].op, exp_q[i].tag, exp_q[i].err})
        $display("FAIL rand_rsp[%0d] got=%h/%0d/%0d/%0b want=%h/%0d/%0d/%0b", i, obs_q[i].res, obs_q[i].op, obs_q[i].tag, obs_q[i].err, exp_q[i].res, exp_q[i].op, exp_q[i].tag, exp_q[i].err);
      else passes++;
    end
    checks++; if (hold_viol != 0) $display("FAIL rand_rsp_hold got=%0d_changes want=0", hold_viol); else passes++;
    checks++; if (busy !== 1'b0 || fifo_count !== '0) $display("FAIL rand_idle got=%0b/%0d want=0/0", busy, fifo_count); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_back_to_back();
    test_div_err();
    test_logic_ops();
    test_backpressure();
    test_reset_midflight();
    test_tag_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish passed=%0d checks=%0d", passes, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
